cnt_wrap_monitor: RTL and testbench
===================================

Name: cnt_wrap_monitor

Overview:
- Sits directly downstream of the mod-N up/down counter.
- Each clock it samples the counter's 3-bit count, modulus n, direction ud and the counter's sync reset.
- Checks every count transition against the legal mod-N sequence.
- Emits a terminal-count (wrap) pulse, keeps a signed-direction wrap accumulator as a cascade "next digit", and latches a sticky fault on any illegal step.

Parameters:
- CNT_W, 3, width of count and n inputs
- WRAP_W, 8, width of wrap accumulator

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset of this block
- count  in  CNT_W  counter output under observation
- n  in  CNT_W  modulus driven to the counter
- ud  in  1  direction driven to the counter; 1=up, 0=down
- ctr_reset  in  1  synchronous reset driven to the counter
- clr_fault  in  1  single-cycle clear of fault state
- tc  out  1  one-cycle pulse on a legal wrap
- wraps  out  WRAP_W  wrap accumulator; +1 on up-wrap, -1 on down-wrap
- step_err  out  1  one-cycle pulse on the first illegal transition
- fault  out  1  sticky fault flag
- tracking  out  1  high while in TRACK state

Behaviour:
- Reset values (async, reset=1): tc=0, wraps=0, step_err=0, fault=0, tracking=0, state=IDLE.
- Internal registers:
  - prev (CNT_W)
  - ud_q, n_q, rst_q: ud, n and ctr_reset registered every edge.
  - Every count value is judged against the ud_q/n_q/rst_q that produced it, i.e. the values sampled at the same edge the counter used.
- Arithmetic: all count arithmetic is modulo 2^CNT_W.
  - n-1 with n=0 gives 7; that is a legal full mod-8 sequence.
- Expected next value, with prev==count of the previous cycle:
  - ud_q=1: prev==n_q-1 ? 0 : prev+1
  - ud_q=0: prev==0 ? n_q-1 : prev-1
  - Covers down-mode reset value n: n -> n-1 is legal.
- State IDLE:
  - tracking=0, no checks.
  - Any edge with rst_q=0 and ctr_reset=0: prev<=count, go TRACK.
- State TRACK (tracking=1), each edge:
  - rst_q=1: current count is a reset value, no check; prev<=count, stay TRACK.
  - count==expected, up-wrap (ud_q=1, prev==n_q-1, count==0): tc=1 next cycle, wraps<=wraps+1.
  - count==expected, down-wrap (ud_q=0, prev==0, count==n_q-1): tc=1 next cycle, wraps<=wraps-1.
  - count==expected, otherwise: tc=0, prev<=count.
  - count!=expected (includes holds, skips, out-of-range jumps): step_err=1 for one cycle, fault<=1, go FAULT; wraps unchanged.
- State FAULT:
  - fault=1, tc=0, wraps frozen, no checks, step_err stays 0.
  - clr_fault=1: fault<=0, go IDLE (resync next cycle).
- Latency: tc and step_err assert on the edge after the offending/wrapping count is present on the input (one registered stage).
- Simultaneous events:
  - clr_fault in TRACK/IDLE is ignored.
  - ctr_reset has priority over checking.
  - reset has priority over everything.
- n=1 up: 0->0 each cycle is a legal wrap every cycle (tc held high, wraps +1 per cycle).
- n or ud change: legal mid-run; the expected value uses the values the counter itself used (ud_q, n_q).
- Default wraps wraps modulo 2^WRAP_W: 255+1 -> 0, 0-1 -> 255.

Optional Feature:
- Macro CNT_WRAP_SAT_EN.
- Defined: wraps saturates; up-wrap at 2^WRAP_W-1 holds value, down-wrap at 0 holds 0. tc still pulses.
- Undefined: modulo behaviour as above.

Test Plan:
- n=5, ud=1, ctr_reset pulse then free run 12 cycles: count 0,1,2,3,4,0,... -> tc one cycle after each 4->0, wraps=2, no step_err.
- n=5, ud=0, ctr_reset (count=5) then run: 5,4,3,2,1,0,4,... -> no error on 5->4, tc after 0->4, wraps=255 (macro off) / 0 (CNT_WRAP_SAT_EN).
- Up-run n=6, flip ud to 0 at count=3: sequence 3,2,1,0,5 -> no step_err, tc after 0->5, wraps net -1 from prior value.
- Force count 2->5 in TRACK with n=7 up: step_err one cycle, fault=1, tracking=0. Further wraps give no tc. clr_fault -> IDLE, then TRACK next cycle, fault=0.
- n=0, ud=1: 0..7,0 -> tc after 7->0, no error. n=1, ud=1: tc high every cycle, wraps +1 per cycle.
- Assert reset mid-TRACK with wraps=3: all outputs 0 immediately (asynchronous). On release, IDLE then TRACK after first sample.

Source files
------------

// File: rtl/cnt_wrap_monitor.sv
// Checker for a mod-N up/down counter: flags illegal steps, pulses tc on wraps
// and keeps a signed wrap accumulator. Define CNT_WRAP_SAT_EN for a saturating accumulator.
module cnt_wrap_monitor #(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  n,
  input  logic              ud,
  input  logic              ctr_reset,
  input  logic              clr_fault,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps,
  output logic              step_err,
  output logic              fault,
  output logic              tracking
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    prev;
  logic [CNT_W-1:0]    n_q;
  logic                ud_q;
  logic                rst_q;

  logic [CNT_W-1:0]    n_m1;
  logic [CNT_W-1:0]    expected;
  logic                legal;
  logic                up_wrap;
  logic                dn_wrap;
  logic [WRAP_W-1:0]   wraps_up;
  logic [WRAP_W-1:0]   wraps_dn;

  // Expected next count from the controls the counter used for this step.
  always_comb begin
    n_m1     = n_q - CNT_W'(1);
    expected = '0;
    if (ud_q) begin
      expected = (prev == n_m1) ? '0 : prev + CNT_W'(1);
    end else begin
      expected = (prev == '0) ? n_m1 : prev - CNT_W'(1);
    end
    legal   = (count == expected);
    up_wrap = ud_q  && (prev == n_m1) && (count == '0);
    dn_wrap = !ud_q && (prev == '0)   && (count == n_m1);
  end

  // Next accumulator values for each wrap direction.
  always_comb begin
`ifdef CNT_WRAP_SAT_EN
    wraps_up = (wraps == '1) ? wraps : wraps + WRAP_W'(1);
    wraps_dn = (wraps == '0) ? wraps : wraps - WRAP_W'(1);
`else
    wraps_up = wraps + WRAP_W'(1);
    wraps_dn = wraps - WRAP_W'(1);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prev     <= '0;
      n_q      <= '0;
      ud_q     <= 1'b0;
      rst_q    <= 1'b0;
      tc       <= 1'b0;
      wraps    <= '0;
      step_err <= 1'b0;
      fault    <= 1'b0;
      tracking <= 1'b0;
    end else begin
      n_q      <= n;
      ud_q     <= ud;
      rst_q    <= ctr_reset;
      tc       <= 1'b0;
      step_err <= 1'b0;
      case (state)
        IDLE: begin
          // Resync only once the counter is out of reset on both sides of the edge.
          if (!rst_q && !ctr_reset) begin
            prev     <= count;
            state    <= TRACK;
            tracking <= 1'b1;
          end
        end
        TRACK: begin
          if (rst_q) begin
            prev <= count;
          end else if (legal) begin
            prev <= count;
            if (up_wrap) begin
              tc    <= 1'b1;
              wraps <= wraps_up;
            end else if (dn_wrap) begin
              tc    <= 1'b1;
              wraps <= wraps_dn;
            end
          end else begin
            step_err <= 1'b1;
            fault    <= 1'b1;
            state    <= FAULT;
            tracking <= 1'b0;
          end
        end
        FAULT: begin
          if (clr_fault) begin
            fault <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          tracking <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_wrap_monitor.sv
// Directed self-checking bench for cnt_wrap_monitor; counts are driven as the counter would produce them.
module tb_cnt_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] count = 3'd0;
  logic [2:0] n = 3'd0;
  logic       ud = 1'b1;
  logic       ctr_reset = 1'b0;
  logic       clr_fault = 1'b0;
  logic       tc;
  logic [7:0] wraps;
  logic       step_err;
  logic       fault;
  logic       tracking;

  int total = 0;
  int bad = 0;

`ifdef CNT_WRAP_SAT_EN
  localparam logic [7:0] DOWN_FROM_0  = 8'd0;
  localparam logic [7:0] UP_FROM_255  = 8'd255;
`else
  localparam logic [7:0] DOWN_FROM_0  = 8'd255;
  localparam logic [7:0] UP_FROM_255  = 8'd0;
`endif

  cnt_wrap_monitor #(.CNT_W(3), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .count(count), .n(n), .ud(ud),
    .ctr_reset(ctr_reset), .clr_fault(clr_fault), .tc(tc), .wraps(wraps),
    .step_err(step_err), .fault(fault), .tracking(tracking)
  );

  always #5 clk = ~clk;

  // Present one cycle of counter output plus the controls for the next edge.
  task automatic drive(input logic [2:0] c, input logic [2:0] nn, input logic u,
                       input logic r, input logic cf);
    count = c; n = nn; ud = u; ctr_reset = r; clr_fault = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; count = 3'd0; ctr_reset = 1'b0; clr_fault = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL rst_tc: got %b want 0", tc); end
    total++; if (wraps !== 8'd0) begin bad++; $display("FAIL rst_wraps: got %0d want 0", wraps); end
    total++; if (step_err !== 1'b0) begin bad++; $display("FAIL rst_step_err: got %b want 0", step_err); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fault); end
    total++; if (tracking !== 1'b0) begin bad++; $display("FAIL rst_tracking: got %b want 0", tracking); end
  endtask

  task automatic test_up_wrap();
    logic [2:0] seq [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    logic       etc [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       etr [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    drive(3'd0, 3'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(seq[i], 3'd5, 1'b1, 1'b0, 1'b0);
      total++; if (tc !== etc[i]) begin bad++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, etc[i]); end
      total++; if (tracking !== etr[i]) begin bad++; $display("FAIL up_tracking[%0d]: got %b want %b", i, tracking, etr[i]); end
      total++; if (step_err !== 1'b0) begin bad++; $display("FAIL up_step_err[%0d]: got %b want 0", i, step_err); end
    end
    total++; if (wraps !== 8'd2) begin bad++; $display("FAIL up_wraps: got %0d want 2", wraps); end
  endtask

  task automatic test_down_wrap();
    logic [2:0] seq [10] = '{3'd3, 3'd2, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3};
    logic       rs  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       etc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(seq[i], 3'd5, 1'b0, rs[i], 1'b0);
      total++; if (tc !== etc[i]) begin bad++; $display("FAIL dn_tc[%0d]: got %b want %b", i, tc, etc[i]); end
      total++; if (step_err !== 1'b0) begin bad++; $display("FAIL dn_step_err[%0d]: got %b want 0", i, step_err); end
      total++; if (tracking !== 1'b1) begin bad++; $display("FAIL dn_tracking[%0d]: got %b want 1", i, tracking); end
    end
    total++; if (wraps !== DOWN_FROM_0) begin bad++; $display("FAIL dn_wraps: got %0d want %0d", wraps, DOWN_FROM_0); end
  endtask

  task automatic test_dir_flip();
    logic [2:0] seq [15] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4};
    logic       dir [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       etc [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      drive(seq[i], 3'd6, dir[i], 1'b0, 1'b0);
      total++; if (tc !== etc[i]) begin bad++; $display("FAIL flip_tc[%0d]: got %b want %b", i, tc, etc[i]); end
      total++; if (step_err !== 1'b0) begin bad++; $display("FAIL flip_step_err[%0d]: got %b want 0", i, step_err); end
      if (i == 12) begin
        total++; if (wraps !== 8'd1) begin bad++; $display("FAIL flip_wraps_mid: got %0d want 1", wraps); end
      end
    end
    total++; if (wraps !== 8'd0) begin bad++; $display("FAIL flip_wraps: got %0d want 0", wraps); end
  endtask

  task automatic test_fault();
    apply_reset();
    drive(3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    drive(3'd1, 3'd7, 1'b1, 1'b0, 1'b0);
    drive(3'd2, 3'd7, 1'b1, 1'b0, 1'b0);
    drive(3'd5, 3'd7, 1'b1, 1'b0, 1'b0);
    total++; if (step_err !== 1'b1) begin bad++; $display("FAIL flt_step_err: got %b want 1", step_err); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL flt_fault: got %b want 1", fault); end
    total++; if (tracking !== 1'b0) begin bad++; $display("FAIL flt_tracking: got %b want 0", tracking); end
    drive(3'd6, 3'd7, 1'b1, 1'b0, 1'b0);
    total++; if (step_err !== 1'b0) begin bad++; $display("FAIL flt_step_err_1cyc: got %b want 0", step_err); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL flt_sticky: got %b want 1", fault); end
    drive(3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL flt_no_tc: got %b want 0", tc); end
    total++; if (wraps !== 8'd0) begin bad++; $display("FAIL flt_wraps_frozen: got %0d want 0", wraps); end
    drive(3'd1, 3'd7, 1'b1, 1'b0, 1'b1);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL flt_clear: got %b want 0", fault); end
    total++; if (tracking !== 1'b0) begin bad++; $display("FAIL flt_idle: got %b want 0", tracking); end
    drive(3'd2, 3'd7, 1'b1, 1'b0, 1'b0);
    total++; if (tracking !== 1'b1) begin bad++; $display("FAIL flt_resync: got %b want 1", tracking); end
    drive(3'd3, 3'd7, 1'b1, 1'b0, 1'b0);
    total++; if (step_err !== 1'b0) begin bad++; $display("FAIL flt_legal_after: got %b want 0", step_err); end
    drive(3'd4, 3'd7, 1'b1, 1'b0, 1'b1);
    total++; if (tracking !== 1'b1) begin bad++; $display("FAIL flt_clr_in_track: got %b want 1", tracking); end
    drive(3'd4, 3'd7, 1'b1, 1'b0, 1'b0);
    total++; if (step_err !== 1'b1) begin bad++; $display("FAIL flt_hold_err: got %b want 1", step_err); end
  endtask

  task automatic test_n0_n1();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(3'(i), 3'd0, 1'b1, 1'b0, 1'b0);
      total++; if (tc !== (i == 8)) begin bad++; $display("FAIL n0_tc[%0d]: got %b want %b", i, tc, (i == 8)); end
      total++; if (step_err !== 1'b0) begin bad++; $display("FAIL n0_step_err[%0d]: got %b want 0", i, step_err); end
    end
    total++; if (wraps !== 8'd1) begin bad++; $display("FAIL n0_wraps: got %0d want 1", wraps); end
    apply_reset();
    drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL n1_entry_tc: got %b want 0", tc); end
    for (int i = 1; i <= 4; i++) begin
      drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
      total++; if (tc !== 1'b1) begin bad++; $display("FAIL n1_tc[%0d]: got %b want 1", i, tc); end
      total++; if (wraps !== 8'(i)) begin bad++; $display("FAIL n1_wraps[%0d]: got %0d want %0d", i, wraps, i); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    total++; if (wraps !== 8'd3) begin bad++; $display("FAIL ar_pre_wraps: got %0d want 3", wraps); end
    #2 reset = 1'b1;
    #1;
    total++; if ({tc, wraps, step_err, fault, tracking} !== 12'd0)
      begin bad++; $display("FAIL ar_outputs: got %h want 0", {tc, wraps, step_err, fault, tracking}); end
    @(negedge clk);
    reset = 1'b0;
    total++; if (tracking !== 1'b0) begin bad++; $display("FAIL ar_idle: got %b want 0", tracking); end
    drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    total++; if (tracking !== 1'b1) begin bad++; $display("FAIL ar_track: got %b want 1", tracking); end
    drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    total++; if (wraps !== 8'd1) begin bad++; $display("FAIL ar_wraps: got %0d want 1", wraps); end
  endtask

  task automatic test_wrap_boundary();
    apply_reset();
    drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    total++; if (wraps !== 8'd255) begin bad++; $display("FAIL bnd_255: got %0d want 255", wraps); end
    drive(3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    total++; if (wraps !== UP_FROM_255) begin bad++; $display("FAIL bnd_over: got %0d want %0d", wraps, UP_FROM_255); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL bnd_tc: got %b want 1", tc); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_dir_flip();
    test_fault();
    test_n0_n1();
    test_async_reset();
    test_wrap_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
